// File: rtl/mem_unit_if.sv
// rtl/mem_unit_if.sv - request/response bus between the LC-3 control/datapath and mem_unit.
interface mem_unit_if;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        mem_busy;

    modport master (
        output mem_en, mem_rw, mar, mdr_in,
        input  mem_data, mem_ready, mem_busy
    );

    modport slave (
        input  mem_en, mem_rw, mar, mdr_in,
        output mem_data, mem_ready, mem_busy
    );
endinterface

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - LC-3 memory unit: wait-stated request FSM over word RAM.
// Define LC3_MMIO_EN to map the KBSR/KBDR/DSR/DDR device registers ahead of RAM.
module mem_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    mem_unit_if.slave  bus,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_data,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    input  logic       disp_ready
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, wdata_q, mem_data_q;
    logic        rw_q;
    logic        fire;
    logic        stall;
    logic        dev_hit;
    logic [15:0] dev_rdata;
    logic        in_range;
    logic [15:0] rdata;

    logic [15:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_en) begin
                    state_d = S_ACCESS;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!stall) begin
                    fire    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:    state_d = bus.mem_en ? S_RELEASE : S_IDLE;
            default:   if (!bus.mem_en) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rw_q       <= 1'b0;
            mem_data_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.mem_en) begin
                addr_q  <= bus.mar;
                wdata_q <= bus.mdr_in;
                rw_q    <= bus.mem_rw;
            end
            if (fire && !rw_q) mem_data_q <= rdata;
        end
    end

    // Full 16-bit compare so addresses past DEPTH never alias onto low RAM.
    assign in_range = ({16'h0000, addr_q} < 32'(DEPTH));
    assign rdata    = dev_hit ? dev_rdata : (in_range ? ram[addr_q[AW-1:0]] : 16'h0000);

    always_ff @(posedge clk) begin
        if (fire && rw_q && in_range && !dev_hit) ram[addr_q[AW-1:0]] <= wdata_q;
    end

`ifdef LC3_MMIO_EN
    logic       kbd_full_q;
    logic [7:0] kbd_byte_q;
    logic       disp_valid_q;
    logic [7:0] disp_data_q;
    logic       hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, kbdr_read;

    assign hit_kbsr  = (addr_q == 16'hFE00);
    assign hit_kbdr  = (addr_q == 16'hFE02);
    assign hit_dsr   = (addr_q == 16'hFE04);
    assign hit_ddr   = (addr_q == 16'hFE06);
    assign dev_hit   = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;
    assign dev_rdata = hit_kbsr ? {kbd_full_q, 15'b0} :
                       hit_kbdr ? {8'h00, kbd_byte_q} :
                       hit_dsr  ? {~disp_valid_q, 15'b0} : 16'h0000;
    assign stall     = rw_q && hit_ddr && disp_valid_q;
    assign kbdr_read = fire && !rw_q && hit_kbdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbd_full_q   <= 1'b0;
            kbd_byte_q   <= 8'h00;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            // A byte arriving with the KBDR read replaces the consumed one.
            if (kbd_valid && (!kbd_full_q || kbdr_read)) begin
                kbd_byte_q <= kbd_data;
                kbd_full_q <= 1'b1;
            end else if (kbdr_read) begin
                kbd_full_q <= 1'b0;
            end
            if (disp_valid_q && disp_ready) disp_valid_q <= 1'b0;
            if (fire && rw_q && hit_ddr) begin
                disp_valid_q <= 1'b1;
                disp_data_q  <= wdata_q[7:0];
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
`else
    logic unused_dev;
    assign unused_dev = ^{kbd_valid, kbd_data, disp_ready};
    assign dev_hit    = 1'b0;
    assign dev_rdata  = 16'h0000;
    assign stall      = 1'b0;
    assign disp_valid = 1'b0;
    assign disp_data  = 8'h00;
`endif

    assign bus.mem_data  = mem_data_q;
    assign bus.mem_ready = (state_q == S_DONE);
    assign bus.mem_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed, table-driven bench for mem_unit.
module tb_mem_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       disp_ready = 1'b0;
    int         checks = 0;
    int         errors = 0;

    mem_unit_if bif ();

    mem_unit #(.DEPTH(1024), .WAIT_STATES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif.slave),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One-cycle strobe; returns edges from sampling edge to mem_ready (-1 on timeout).
    task automatic req(input logic rw, input logic [15:0] a, input logic [15:0] d, output int lat);
        @(negedge clk);
        bif.mem_en = 1'b1; bif.mem_rw = rw; bif.mar = a; bif.mdr_in = d;
        @(posedge clk); #1;
        bif.mem_en = 1'b0; bif.mem_rw = ~rw; bif.mar = 16'hFFFF; bif.mdr_in = 16'hDEAD;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bif.mem_ready) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int pulses;
        bif.mem_en = 1'b0; bif.mem_rw = 1'b0; bif.mar = 16'h0000; bif.mdr_in = 16'h0000;

        vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 2};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 2};
        vecs[2]  = '{1'b1, 16'h0003, 16'h00AB, 16'h1234, 2};
        vecs[3]  = '{1'b0, 16'h0003, 16'h0000, 16'h00AB, 2};
        vecs[4]  = '{1'b1, 16'h0000, 16'h7777, 16'h00AB, 2};
        vecs[5]  = '{1'b1, 16'h03FF, 16'hCAFE, 16'h00AB, 2};
        vecs[6]  = '{1'b1, 16'h0400, 16'hBEEF, 16'h00AB, 2};
        vecs[7]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 2};
        vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h7777, 2};
        vecs[9]  = '{1'b0, 16'h03FF, 16'h0000, 16'hCAFE, 2};
        vecs[10] = '{1'b1, 16'h8000, 16'h1111, 16'hCAFE, 2};
        vecs[11] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 2};

        #12;
        check("reset_mem_data", 32'(bif.mem_data), 32'h0);
        check("reset_ready", 32'(bif.mem_ready), 32'h0);
        check("reset_busy", 32'(bif.mem_busy), 32'h0);
        check("reset_disp_valid", 32'(disp_valid), 32'h0);
        check("reset_disp_data", 32'(disp_data), 32'h0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_mem_data", i), 32'(bif.mem_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_idle", i), 32'(bif.mem_busy), 32'h0);
        end

        // Held strobe: one access, then park in RELEASE until mem_en drops.
        @(negedge clk);
        bif.mem_en = 1'b1; bif.mem_rw = 1'b0; bif.mar = 16'h0003;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bif.mem_ready) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_release_busy", 32'(bif.mem_busy), 32'h1);
        check("held_mem_data", 32'(bif.mem_data), 32'h00AB);
        @(negedge clk); bif.mem_en = 1'b0;
        @(posedge clk); #1;
        check("held_back_to_idle", 32'(bif.mem_busy), 32'h0);

        // Reset during ACCESS of a write: write lost, no ready pulse.
        req(1'b1, 16'h0020, 16'h0A0A, lat);
        check("pre_reset_write_lat", 32'(lat), 32'd2);
        @(negedge clk);
        bif.mem_en = 1'b1; bif.mem_rw = 1'b1; bif.mar = 16'h0020; bif.mdr_in = 16'h5555;
        @(posedge clk); #1;
        bif.mem_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy_async", 32'(bif.mem_busy), 32'h0);
        pulses = 0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bif.mem_ready) pulses++;
        end
        check("rst_no_ready", 32'(pulses), 32'd0);
        check("rst_mem_data_cleared", 32'(bif.mem_data), 32'h0);
        req(1'b0, 16'h0020, 16'h0000, lat);
        check("rst_prior_contents", 32'(bif.mem_data), 32'h0A0A);
        req(1'b0, 16'h0010, 16'h0000, lat);
        check("ram_survives_reset", 32'(bif.mem_data), 32'h1234);

`ifdef LC3_MMIO_EN
        @(negedge clk); kbd_valid = 1'b1; kbd_data = 8'h41;
        @(negedge clk); kbd_valid = 1'b0; kbd_data = 8'h00;
        req(1'b0, 16'hFE00, 16'h0000, lat);
        check("kbsr_full", 32'(bif.mem_data), 32'h8000);
        req(1'b0, 16'hFE02, 16'h0000, lat);
        check("kbdr_byte", 32'(bif.mem_data), 32'h0041);
        req(1'b0, 16'hFE00, 16'h0000, lat);
        check("kbsr_cleared", 32'(bif.mem_data), 32'h0000);

        disp_ready = 1'b0;
        req(1'b1, 16'hFE06, 16'h0042, lat);
        check("ddr_write_lat", 32'(lat), 32'd2);
        check("ddr_valid", 32'(disp_valid), 32'h1);
        check("ddr_data", 32'(disp_data), 32'h42);
        req(1'b0, 16'hFE04, 16'h0000, lat);
        check("dsr_busy", 32'(bif.mem_data), 32'h0000);
        @(negedge clk);
        bif.mem_en = 1'b1; bif.mem_rw = 1'b1; bif.mar = 16'hFE06; bif.mdr_in = 16'h0043;
        @(posedge clk); #1;
        bif.mem_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bif.mem_ready) pulses++;
        end
        check("ddr_stall_no_ready", 32'(pulses), 32'd0);
        check("ddr_stall_busy", 32'(bif.mem_busy), 32'h1);
        @(negedge clk); disp_ready = 1'b1;
        @(posedge clk); #1;
        check("ddr_transfer_clears", 32'(disp_valid), 32'h0);
        check("ddr_transfer_data", 32'(disp_data), 32'h42);
        @(negedge clk); disp_ready = 1'b0;
        @(posedge clk); #1;
        check("ddr_second_ready", 32'(bif.mem_ready), 32'h1);
        check("ddr_second_data", 32'(disp_data), 32'h43);
        check("ddr_second_valid", 32'(disp_valid), 32'h1);
        @(posedge clk); #1;
`else
        @(negedge clk); kbd_valid = 1'b1; kbd_data = 8'h41; disp_ready = 1'b1;
        @(negedge clk); kbd_valid = 1'b0;
        req(1'b1, 16'hFE06, 16'h0042, lat);
        check("nommio_disp_valid", 32'(disp_valid), 32'h0);
        check("nommio_disp_data", 32'(disp_data), 32'h0);
        req(1'b0, 16'hFE00, 16'h0000, lat);
        check("nommio_kbsr_is_ram_oor", 32'(bif.mem_data), 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
